// File: rtl/text_console_ctrl.sv
// Console sequencer for the 32x28 text overlay: turns PUTC/GOTO/CLEAR/CLEAR_EOL
// commands into single-cycle writes on the overlay character register.
module text_console_ctrl #(
   parameter int         COLS      = 32,
   parameter int         ROWS      = 28,
   parameter logic [7:0] FILL_CHAR = 8'h20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_data,
   output logic [3:0]  reg_char_we,
   output logic [31:0] reg_char_di,
   output logic [4:0]  cursor_x,
   output logic [4:0]  cursor_y,
   output logic        busy
);

   localparam logic [4:0] XMAX = 5'(COLS - 1);
   localparam logic [4:0] YMAX = 5'(ROWS - 1);
   localparam logic [9:0] LAST = 10'(COLS * ROWS - 1);

   typedef enum logic [1:0] {IDLE, CLR, EOL} state_e;

   state_e      state_q;
   logic [4:0]  x_q, y_q;
   logic [9:0]  cnt_q;
   logic [3:0]  we_q;
   logic [31:0] di_q;
   logic        busy_q;

   logic [7:0]  ch;
   logic [4:0]  x_d, y_d, y_inc, goto_y;
   logic        put_wr;
   logic [9:0]  cnt_nx;
   logic        unused_cmd_bits;

   function automatic logic [31:0] pack(input logic [4:0] x, input logic [4:0] y,
                                        input logic [7:0] c);
      return {8'h00, 3'b000, x, 3'b000, y, c};
   endfunction

   assign ch              = cmd_data[7:0];
   assign cnt_nx          = cnt_q + 10'd1;
   assign unused_cmd_bits = ^cmd_data[15:13];
   assign goto_y          = (cmd_data[12:8] > YMAX) ? YMAX : cmd_data[12:8];
   assign y_inc           = (y_q == YMAX) ? '0 : y_q + 5'd1;

   // Cursor update for PUTC; printable means 0x20..0x7E or anything >= 0x80.
   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      put_wr = 1'b0;
      if (ch >= 8'h20 && ch != 8'h7F) begin
         put_wr = 1'b1;
         if (x_q == XMAX) begin
            x_d = '0;
            y_d = y_inc;
         end else begin
            x_d = x_q + 5'd1;
         end
      end else begin
         case (ch)
            8'h0A: begin
               x_d = '0;
               y_d = y_inc;
            end
            8'h0D: x_d = '0;
            8'h08: if (x_q != '0) x_d = x_q - 5'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         we_q    <= '0;
         di_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         we_q <= '0;
         di_q <= '0;
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op)
                     2'd0: begin
                        x_q <= x_d;
                        y_q <= y_d;
                        if (put_wr) begin
                           we_q <= 4'b0001;
                           di_q <= pack(x_q, y_q, ch);
                        end
                     end
                     2'd1: begin
                        x_q <= cmd_data[4:0];
                        y_q <= goto_y;
                     end
                     2'd2: begin
                        state_q <= CLR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        we_q    <= 4'b0001;
                        di_q    <= pack('0, '0, FILL_CHAR);
                     end
                     default: begin
                        state_q <= EOL;
                        busy_q  <= 1'b1;
                        cnt_q   <= {5'b00000, x_q};
                        we_q    <= 4'b0001;
                        di_q    <= pack(x_q, y_q, FILL_CHAR);
                     end
                  endcase
               end
            end
            // cnt_q holds the index of the write currently on the outputs.
            CLR: begin
               if (cnt_q == LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  x_q     <= '0;
                  y_q     <= '0;
               end else begin
                  cnt_q <= cnt_nx;
                  we_q  <= 4'b0001;
                  di_q  <= pack(cnt_nx[4:0], cnt_nx[9:5], FILL_CHAR);
               end
            end
            EOL: begin
               if (cnt_q[4:0] == XMAX) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_nx;
                  we_q  <= 4'b0001;
                  di_q  <= pack(cnt_nx[4:0], y_q, FILL_CHAR);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE) && !reset;
   assign reg_char_we = we_q;
   assign reg_char_di = di_q;
   assign cursor_x    = x_q;
   assign cursor_y    = y_q;
   assign busy        = busy_q;

endmodule
